// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake-game geometry, coordinate widths, spawner FSM states and clog2 helper
package snake_pkg;

    localparam int DISPLAY_W = 240;
    localparam int DISPLAY_H = 320;
    localparam int BORDER    = 10;
    localparam int APPLE_W   = 10;
    localparam int APPLE_H   = 10;
    localparam int SEG_W     = 10;
    localparam int SEG_H     = 10;
    localparam int MAX_SEG   = 128;

    localparam int XW = 8;
    localparam int YW = 9;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SCAN,
        COMMIT
    } spawn_state_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit maximal-length Galois LFSR (x^16+x^14+x^13+x^11+1) with load-on-reset seed
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] value
);

    // Right-shifting form: the bit falling out of bit 0 is fed back through the tap mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (enable) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/apple_spawner.sv
// rtl/apple_spawner.sv - grid-aligned apple placement avoiding snake segments; APPLE_SPAWN_RETRY_LIMIT_EN bounds the redraws
module apple_spawner #(
    parameter int          DISPLAY_W   = snake_pkg::DISPLAY_W,
    parameter int          DISPLAY_H   = snake_pkg::DISPLAY_H,
    parameter int          BORDER      = snake_pkg::BORDER,
    parameter int          APPLE_W     = snake_pkg::APPLE_W,
    parameter int          APPLE_H     = snake_pkg::APPLE_H,
    parameter int          SEG_W       = snake_pkg::SEG_W,
    parameter int          SEG_H       = snake_pkg::SEG_H,
    parameter int          MAX_SEG     = snake_pkg::MAX_SEG,
    parameter int          XW          = snake_pkg::XW,
    parameter int          YW          = snake_pkg::YW,
    parameter int          SW          = 8,
    parameter int          INIT_X      = 100,
    parameter int          INIT_Y      = 200,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          MAX_RETRIES = 64,
    parameter int          FALLBACK_X  = 150,
    parameter int          FALLBACK_Y  = 150
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  appleEaten,
    input  logic [MAX_SEG*XW-1:0] snakeLocX,
    input  logic [MAX_SEG*YW-1:0] snakeLocY,
    input  logic [SW-1:0]         size,
    output logic [XW-1:0]         appleLocX,
    output logic [YW-1:0]         appleLocY,
    output logic                  appleValid,
    output logic                  busy,
    output logic                  fallbackUsed
);

    import snake_pkg::*;

    localparam int CELLS_X  = (DISPLAY_W - 2 * BORDER) / APPLE_W;
    localparam int CELLS_Y  = (DISPLAY_H - 2 * BORDER) / APPLE_H;
    localparam int CX_BITS  = (clog2(CELLS_X) < 1) ? 1 : clog2(CELLS_X);
    localparam int CY_BITS  = (clog2(CELLS_Y) < 1) ? 1 : clog2(CELLS_Y);
    localparam int RW       = (clog2(MAX_RETRIES + 1) < 1) ? 1 : clog2(MAX_RETRIES + 1);

    spawn_state_t   state;
    logic [15:0]    lfsr;
    logic [CX_BITS-1:0] cx;
    logic [CY_BITS-1:0] cy;
    logic           draw_ok;
    logic [XW-1:0]  draw_x;
    logic [YW-1:0]  draw_y;
    logic [XW-1:0]  cand_x;
    logic [YW-1:0]  cand_y;
    logic [SW-1:0]  eff_size;
    logic [SW-1:0]  index;
    logic [RW-1:0]  retries;
    logic [XW-1:0]  seg_x;
    logic [YW-1:0]  seg_y;
    logic           hit;

    // Free-running so the spawn position depends on when the player eats.
    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .value  (lfsr)
    );

    assign cx      = lfsr[CX_BITS-1:0];
    assign cy      = lfsr[15 -: CY_BITS];
    assign draw_ok = (int'(cx) < CELLS_X) && (int'(cy) < CELLS_Y);
    assign draw_x  = XW'(BORDER + int'(cx) * APPLE_W);
    assign draw_y  = YW'(BORDER + int'(cy) * APPLE_H);

    always_comb begin
        seg_x = '0;
        seg_y = '0;
        for (int i = 0; i < MAX_SEG; i++) begin
            if (index == SW'(i)) begin
                seg_x = snakeLocX[i*XW +: XW];
                seg_y = snakeLocY[i*YW +: YW];
            end
        end
    end

    // One extra bit keeps x+W from wrapping near the right/bottom edge.
    assign hit = ({1'b0, cand_x} < {1'b0, seg_x} + (XW+1)'(SEG_W))   &&
                 ({1'b0, seg_x}  < {1'b0, cand_x} + (XW+1)'(APPLE_W)) &&
                 ({1'b0, cand_y} < {1'b0, seg_y} + (YW+1)'(SEG_H))   &&
                 ({1'b0, seg_y}  < {1'b0, cand_y} + (YW+1)'(APPLE_H));

`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
    logic use_fb;
    logic fb_pulse;
    logic retry_out;
    assign retry_out    = (retries >= RW'(MAX_RETRIES));
    assign fallbackUsed = fb_pulse;
`else
    assign fallbackUsed = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            appleLocX  <= XW'(INIT_X);
            appleLocY  <= YW'(INIT_Y);
            appleValid <= 1'b0;
            busy       <= 1'b0;
            eff_size   <= '0;
            index      <= '0;
            retries    <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
            use_fb     <= 1'b0;
            fb_pulse   <= 1'b0;
`endif
        end else begin
            appleValid <= 1'b0;
`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
            fb_pulse   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (appleEaten) begin
                        eff_size <= (int'(size) > MAX_SEG) ? SW'(MAX_SEG) : size;
                        retries  <= '0;
                        busy     <= 1'b1;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
                    if (retry_out) begin
                        cand_x <= XW'(FALLBACK_X);
                        cand_y <= YW'(FALLBACK_Y);
                        use_fb <= 1'b1;
                        state  <= COMMIT;
                    end else
`endif
                    if (!draw_ok) begin
                        retries <= retries + 1'b1;
                    end else begin
                        cand_x <= draw_x;
                        cand_y <= draw_y;
                        index  <= '0;
                        state  <= (eff_size == '0) ? COMMIT : SCAN;
                    end
                end
                SCAN: begin
`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
                    if (retry_out) begin
                        cand_x <= XW'(FALLBACK_X);
                        cand_y <= YW'(FALLBACK_Y);
                        use_fb <= 1'b1;
                        state  <= COMMIT;
                    end else
`endif
                    if (hit) begin
                        retries <= retries + 1'b1;
                        state   <= DRAW;
                    end else if (index == eff_size - 1'b1) begin
                        state <= COMMIT;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                COMMIT: begin
                    appleLocX  <= cand_x;
                    appleLocY  <= cand_y;
                    appleValid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
                    fb_pulse   <= use_fb;
                    use_fb     <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apple_spawner.sv
// tb/tb_apple_spawner.sv - scoreboard bench for apple_spawner, builds with or without APPLE_SPAWN_RETRY_LIMIT_EN
module tb_apple_spawner;

    localparam int MAX_SEG = 128;
`ifdef APPLE_SPAWN_RETRY_LIMIT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic                  apple_eaten;
    logic [MAX_SEG*8-1:0]  loc_x;
    logic [MAX_SEG*9-1:0]  loc_y;
    logic [7:0]            size;
    logic [7:0]            apple_x;
    logic [8:0]            apple_y;
    logic                  apple_valid, busy, fb_used;

    logic                  eaten2;
    logic [31:0]           loc_x2;
    logic [35:0]           loc_y2;
    logic [7:0]            size2;
    logic [7:0]            apple_x2;
    logic [8:0]            apple_y2;
    logic                  valid2, busy2, fb2;

    apple_spawner dut (
        .clock(clock), .reset(reset), .appleEaten(apple_eaten),
        .snakeLocX(loc_x), .snakeLocY(loc_y), .size(size),
        .appleLocX(apple_x), .appleLocY(apple_y), .appleValid(apple_valid),
        .busy(busy), .fallbackUsed(fb_used)
    );

    apple_spawner #(.DISPLAY_W(40), .DISPLAY_H(40), .MAX_SEG(4), .MAX_RETRIES(8)) dut_full (
        .clock(clock), .reset(reset), .appleEaten(eaten2),
        .snakeLocX(loc_x2), .snakeLocY(loc_y2), .size(size2),
        .appleLocX(apple_x2), .appleLocY(apple_y2), .appleValid(valid2),
        .busy(busy2), .fallbackUsed(fb2)
    );

    // 2x2 arena completely covered: (10,10) (20,10) (10,20) (20,20)
    assign loc_x2 = {8'd20, 8'd10, 8'd20, 8'd10};
    assign loc_y2 = {9'd20, 9'd20, 9'd10, 9'd10};

    int seg_x[MAX_SEG];
    int seg_y[MAX_SEG];

    always_comb begin
        loc_x = '0;
        loc_y = '0;
        for (int i = 0; i < MAX_SEG; i++) begin
            loc_x[i*8 +: 8] = 8'(seg_x[i]);
            loc_y[i*9 +: 9] = 9'(seg_y[i]);
        end
    end

    typedef struct {
        int x;
        int y;
        int cyc;
        bit fb;
        int n;
    } exp_t;

    exp_t q[$];
    exp_t q_full[$];
    int n_cmp = 0;
    int n_bad = 0;
    int valid_seen = 0;
    int valid2_seen = 0;
    int last_x = 100;
    int last_y = 200;
    int cyc = 0;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= nxt(m_lfsr);
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic bit overlaps(input int ax, input int ay, input int sx, input int sy);
        return (ax < sx + 10) && (sx < ax + 10) && (ay < sy + 10) && (sy < ay + 10);
    endfunction

    // 22x30 cell arena: cx from lfsr[4:0], cy from lfsr[15:11]; l0 is the value seen in the first DRAW cycle.
    function automatic void predict(input logic [15:0] l0, input int n,
                                    output int px, output int py, output int lat, output bit fb);
        logic [15:0] l;
        int t, r, cx, cy, hit_at;
        l = l0; t = 1; r = 0; fb = 1'b0; px = 0; py = 0; lat = 0;
        for (int guard = 0; guard < 5000; guard++) begin
            if (FEAT && r >= 64) begin
                px = 150; py = 150; fb = 1'b1; lat = t + 1;
                return;
            end
            cx = int'(l[4:0]);
            cy = int'(l[15:11]);
            if (cx >= 22 || cy >= 30) begin
                r++; t++; l = nxt(l);
            end else begin
                px = 10 + cx * 10;
                py = 10 + cy * 10;
                hit_at = -1;
                for (int i = 0; i < n && hit_at < 0; i++)
                    if (overlaps(px, py, seg_x[i], seg_y[i])) hit_at = i;
                if (hit_at < 0) begin
                    lat = t + n + 1;
                    return;
                end
                for (int k = 0; k < hit_at + 2; k++) l = nxt(l);
                t += hit_at + 2;
                r++;
            end
        end
    endfunction

    exp_t e_mon;
    int   hits;
    always @(negedge clock) begin
        if (!reset && apple_valid) begin
            valid_seen++;
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e_mon = q.pop_front();
                chk("apple_x", int'(apple_x), e_mon.x);
                chk("apple_y", int'(apple_y), e_mon.y);
                chk("commit_cycle", cyc, e_mon.cyc);
                chk("fallback_used", int'(fb_used), int'(e_mon.fb));
                chk("busy_at_commit", int'(busy), 0);
                if (!e_mon.fb) begin
                    chk("x_on_grid", int'(apple_x >= 10 && apple_x <= 220 && (apple_x % 10) == 0), 1);
                    chk("y_on_grid", int'(apple_y >= 10 && apple_y <= 300 && (apple_y % 10) == 0), 1);
                    hits = 0;
                    for (int i = 0; i < e_mon.n; i++)
                        if (overlaps(int'(apple_x), int'(apple_y), seg_x[i], seg_y[i])) hits++;
                    chk("segment_overlap", hits, 0);
                end
                last_x = e_mon.x;
                last_y = e_mon.y;
            end
        end
    end

    exp_t e_mon2;
    always @(negedge clock) begin
        if (!reset && valid2) begin
            valid2_seen++;
            if (q_full.size() == 0) begin
                chk("full_unexpected_valid", 1, 0);
            end else begin
                e_mon2 = q_full.pop_front();
                chk("full_x", int'(apple_x2), e_mon2.x);
                chk("full_y", int'(apple_y2), e_mon2.y);
                chk("full_fallback_used", int'(fb2), int'(e_mon2.fb));
            end
        end
    end

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic issue();
        exp_t e;
        int lat;
        @(negedge clock);
        apple_eaten = 1'b1;
        @(posedge clock);
        #1;
        apple_eaten = 1'b0;
        e.n = (int'(size) > MAX_SEG) ? MAX_SEG : int'(size);
        predict(m_lfsr, e.n, e.x, e.y, lat, e.fb);
        e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, int'(apple_x), 100);
        chk({tag, "_y"}, int'(apple_y), 200);
        chk({tag, "_valid"}, int'(apple_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fb"}, int'(fb_used), 0);
    endtask

    initial begin
        int v0, k;
        exp_t ef;
        apple_eaten = 1'b0;
        eaten2 = 1'b0;
        size = 8'd0;
        size2 = 8'd4;
        for (int i = 0; i < MAX_SEG; i++) begin
            seg_x[i] = 0;
            seg_y[i] = 0;
        end
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        chk("reset_full_busy", int'(busy2), 0);
        @(negedge clock);
        reset = 1'b0;

        // Empty snake: two-edge latency plus one cycle per rejected draw.
        repeat (20) begin
            issue();
            wait_drain();
        end
        repeat (20) @(negedge clock);
        chk("hold_x", int'(apple_x), last_x);
        chk("hold_y", int'(apple_y), last_y);
        chk("hold_busy", int'(busy), 0);

        seg_x[0] = 10;  seg_y[0] = 10;
        seg_x[1] = 20;  seg_y[1] = 10;
        seg_x[2] = 100; seg_y[2] = 200;
        seg_x[3] = 215; seg_y[3] = 295;
        seg_x[4] = 15;  seg_y[4] = 155;
        size = 8'd5;
        repeat (1000) begin
            issue();
            wait_drain();
        end

        // Oversized request is clamped to MAX_SEG; the unused segments sit at (0,0) in the border.
        size = 8'd200;
        repeat (4) begin
            issue();
            wait_drain();
        end

        // Second request while busy is dropped and a size change mid-spawn is ignored.
        size = 8'd5;
        v0 = valid_seen;
        issue();
        size = 8'd0;
        @(negedge clock);
        @(negedge clock);
        apple_eaten = 1'b1;
        @(negedge clock);
        apple_eaten = 1'b0;
        wait_drain();
        repeat (200) @(negedge clock);
        chk("single_valid_pulse", valid_seen - v0, 1);
        size = 8'd5;

        // Reset in the middle of a spawn.
        @(negedge clock);
        apple_eaten = 1'b1;
        @(posedge clock);
        #1 apple_eaten = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset_values("midspawn_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        chk("no_valid_after_abort", int'(busy), 0);

        // Fully occupied 2x2 arena on the second instance.
        if (FEAT) begin
            ef.x = 150; ef.y = 150; ef.cyc = -1; ef.fb = 1'b1; ef.n = 4;
            q_full.push_back(ef);
        end
        @(negedge clock);
        eaten2 = 1'b1;
        @(negedge clock);
        eaten2 = 1'b0;
        if (FEAT) begin
            k = 0;
            while (q_full.size() != 0 && k < 2000) begin
                @(negedge clock);
                k++;
            end
            chk("full_commit_seen", q_full.size(), 0);
            chk("full_valid_count", valid2_seen, 1);
            chk("full_busy_after", int'(busy2), 0);
        end else begin
            repeat (10000) @(negedge clock);
            chk("full_valid_count", valid2_seen, 0);
            chk("full_busy_held", int'(busy2), 1);
            chk("full_x_held", int'(apple_x2), 100);
            chk("full_y_held", int'(apple_y2), 200);
            chk("full_fb_tied", int'(fb2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
